// File: rtl/ps2_key_rx.sv
// ps2_key_rx
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
//   stop) and tracks the held/released state of five keys from the make and
//   break scan codes.
//
//   Parameters
//     TIMEOUT_CYC : idle clk cycles tolerated between PS/2 clock falling
//                   edges inside a frame before the frame is abandoned.
//
//   Optional feature (compile-time macro)
//     PS2_PARITY_CHECK_EN : when defined, frames with bad (even) parity are
//                           discarded with a frame_err strobe. When undefined,
//                           the parity bit is sampled and ignored.
//
//   Ports
//     clk        : system clock, all logic on its rising edge
//     rst        : synchronous active-high reset
//     ps2_clk    : raw PS/2 clock (asynchronous)
//     ps2_data   : raw PS/2 data (asynchronous)
//     w_state    : key W (1D) held
//     s_state    : key S (1B) held
//     Ua_state   : Up arrow (E0 75) held
//     Da_state   : Down arrow (E0 72) held
//     ESC_state  : ESC (76) held
//     scan_code  : last correctly received byte
//     code_valid : one-cycle strobe when scan_code updates
//     frame_err  : one-cycle strobe when a frame is discarded
module ps2_key_rx #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w_state,
  output logic       s_state,
  output logic       Ua_state,
  output logic       Da_state,
  output logic       ESC_state,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_CHECK = 1'b1;
`else
  localparam logic PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // PS/2 uses odd parity: data plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  state_t        state_r, state_nxt_s;
  logic          clk_meta_r, clk_sync_r, clk_prev_r;
  logic          data_meta_r, data_sync_r;
  logic          fall_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_s;
  logic          parity_ok_s;
  logic          byte_ok_s;
  logic          frame_bad_s;
  logic          break_r, ext_r;
  logic          w_r, s_r, ua_r, da_r, esc_r;
  logic [7:0]    scan_code_r;
  logic          code_valid_r, frame_err_r;

  assign fall_s      = clk_prev_r & ~clk_sync_r;
  assign tmo_s       = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TMO_LAST);
  assign parity_ok_s = !PARITY_CHECK || odd_parity_ok(shift_r, parity_r);

  // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM next state and end-of-frame decisions.
  always_comb begin
    state_nxt_s = state_r;
    byte_ok_s   = 1'b0;
    frame_bad_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A start bit of 1 is line noise and is silently dropped.
        if (fall_s && !data_sync_r) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s && (bit_cnt_r == 3'd7)) begin
          state_nxt_s = ST_PARITY;
        end else if (tmo_s) begin
          state_nxt_s = ST_IDLE;
          frame_bad_s = 1'b1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          state_nxt_s = ST_STOP;
        end else if (tmo_s) begin
          state_nxt_s = ST_IDLE;
          frame_bad_s = 1'b1;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_nxt_s = ST_IDLE;
          if (data_sync_r && parity_ok_s) begin
            byte_ok_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
        end else if (tmo_s) begin
          state_nxt_s = ST_IDLE;
          frame_bad_s = 1'b1;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bit counter, data shift register, parity capture and inter-edge timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      if (state_r == ST_IDLE) begin
        bit_cnt_r <= 3'd0;
      end else if ((state_r == ST_DATA) && fall_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      // LSB arrives first, so shift in from the top.
      if ((state_r == ST_DATA) && fall_s) begin
        shift_r <= {data_sync_r, shift_r[7:1]};
      end
      if ((state_r == ST_PARITY) && fall_s) begin
        parity_r <= data_sync_r;
      end
      if ((state_r == ST_IDLE) || fall_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      end
    end
  end

  // Byte decode: prefix flags, key table and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      break_r      <= 1'b0;
      ext_r        <= 1'b0;
      w_r          <= 1'b0;
      s_r          <= 1'b0;
      ua_r         <= 1'b0;
      da_r         <= 1'b0;
      esc_r        <= 1'b0;
      scan_code_r  <= 8'h00;
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      code_valid_r <= byte_ok_s;
      frame_err_r  <= frame_bad_s;
      if (byte_ok_s) begin
        scan_code_r <= shift_r;
        if (shift_r == 8'hF0) begin
          break_r <= 1'b1;
        end else if (shift_r == 8'hE0) begin
          ext_r <= 1'b1;
        end else begin
          // The extended flag is part of the key identity, so an arrow code
          // without E0 (or a letter code with it) matches nothing.
          case ({ext_r, shift_r})
            9'h01D:  w_r   <= ~break_r;
            9'h01B:  s_r   <= ~break_r;
            9'h076:  esc_r <= ~break_r;
            9'h175:  ua_r  <= ~break_r;
            9'h172:  da_r  <= ~break_r;
            default: ;
          endcase
          break_r <= 1'b0;
          ext_r   <= 1'b0;
        end
      end
    end
  end

  assign w_state    = w_r;
  assign s_state    = s_r;
  assign Ua_state   = ua_r;
  assign Da_state   = da_r;
  assign ESC_state  = esc_r;
  assign scan_code  = scan_code_r;
  assign code_valid = code_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

  localparam int TMO  = 40;
  localparam int HALF = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       w_state, s_state, Ua_state, Da_state, ESC_state;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state: expected per-frame outcomes (-1 = discarded frame, else byte)
  int         exp_q[$];
  logic [4:0] m_keys = 5'b0;   // {w, s, ua, da, esc}
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic [7:0] m_scan = 8'h00;
  logic       rst_at_edge;

  ps2_key_rx #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .w_state(w_state), .s_state(s_state), .Ua_state(Ua_state),
    .Da_state(Da_state), .ESC_state(ESC_state), .scan_code(scan_code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Key-tracking rules at scan-code level.
  function automatic void apply_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext && b == 8'h1D) m_keys[4] = !m_brk;
      if (!m_ext && b == 8'h1B) m_keys[3] = !m_brk;
      if ( m_ext && b == 8'h75) m_keys[2] = !m_brk;
      if ( m_ext && b == 8'h72) m_keys[1] = !m_brk;
      if (!m_ext && b == 8'h76) m_keys[0] = !m_brk;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endfunction

  // Per-cycle compare of DUT outputs against the model.
  initial begin
    int ev;
    forever begin
      @(posedge clk);
      rst_at_edge = rst;
      @(negedge clk);
      if (rst_at_edge) begin
        m_keys = 5'b0; m_brk = 1'b0; m_ext = 1'b0; m_scan = 8'h00;
        exp_q.delete();
        check("strobes in reset", {30'd0, code_valid, frame_err}, 32'd0);
      end else begin
        if (code_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected code_valid", {24'd0, scan_code}, 32'hFFFF_FFFF);
          end else begin
            ev = exp_q.pop_front();
            check("code_valid byte", {24'd0, scan_code}, ev);
            if (ev >= 0) begin
              m_scan = ev[7:0];
              apply_byte(ev[7:0]);
            end
          end
        end
        if (frame_err === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected frame_err", 32'd1, 32'd0 + exp_q.size());
          end else begin
            ev = exp_q.pop_front();
            check("frame_err event", 32'hFFFF_FFFF, ev);
          end
        end
      end
      check("outputs", {19'd0, w_state, s_state, Ua_state, Da_state, ESC_state, scan_code},
            {19'd0, m_keys, m_scan});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("pending events drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
    logic par;
    par = ~(^b) ^ par_flip;
    if (stop && !(PAR_EN && par_flip)) exp_q.push_back(int'(b));
    else exp_q.push_back(-1);
    send_bits({stop, par, b, 1'b0}, 11);
    drain(100);
  endtask

  task automatic lit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    lit("reset w_state", w_state, 1'b0);
    check("reset scan_code", {24'd0, scan_code}, 32'h00);

    // Make then break of W.
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("W make", w_state, 1'b1);
    check("W make scan", {24'd0, scan_code}, 32'h1D);
    send_byte(8'hF0, 1'b1, 1'b0);
    lit("W held across F0", w_state, 1'b1);
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("W break", w_state, 1'b0);

    // Up arrow and W together, then release Up only.
    send_byte(8'hE0, 1'b1, 1'b0);
    send_byte(8'h75, 1'b1, 1'b0);
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("Ua held", Ua_state, 1'b1);
    lit("W with Ua", w_state, 1'b1);
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("W repeat make", w_state, 1'b1);
    send_byte(8'hE0, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b1, 1'b0);
    send_byte(8'h75, 1'b1, 1'b0);
    lit("Ua released", Ua_state, 1'b0);
    lit("W still held", w_state, 1'b1);

    // Unknown codes: bare 72 and extended 1D change nothing.
    send_byte(8'h72, 1'b1, 1'b0);
    lit("bare 72 ignored", Da_state, 1'b0);
    send_byte(8'hE0, 1'b1, 1'b0);
    send_byte(8'hF0, 1'b1, 1'b0);
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("E0 F0 1D ignored", w_state, 1'b1);
    send_byte(8'hE0, 1'b1, 1'b0);
    send_byte(8'h72, 1'b1, 1'b0);
    lit("Da make", Da_state, 1'b1);

    // Start bit of 1 in idle: no event, no timeout afterwards.
    send_bits(11'h001, 1);
    repeat (TMO + 20) @(negedge clk);

    // Truncated frame then silence: timeout discards it.
    exp_q.push_back(-1);
    send_bits({1'b1, 1'b0, 8'h76, 1'b0}, 9);
    drain(TMO + 60);
    send_byte(8'h76, 1'b1, 1'b0);
    lit("ESC after timeout", ESC_state, 1'b1);

    // Bad parity on S.
    send_byte(8'h1B, 1'b1, 1'b1);
    lit("S after bad parity", s_state, !PAR_EN);

    // Reset mid-frame.
    send_byte(8'h1D, 1'b1, 1'b0);
    send_bits({1'b1, 1'b0, 8'h1B, 1'b0}, 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("outputs after reset", {24'd0, w_state, s_state, Ua_state, Da_state, ESC_state, 3'd0},
          32'd0);
    check("scan after reset", {24'd0, scan_code}, 32'h00);
    repeat (TMO + 20) @(negedge clk);
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("W after reset", w_state, 1'b1);

    // Bad stop bit after F0 keeps the break flag.
    send_byte(8'hF0, 1'b1, 1'b0);
    send_byte(8'h1D, 1'b0, 1'b0);
    lit("W held after bad stop", w_state, 1'b1);
    send_byte(8'h1D, 1'b1, 1'b0);
    lit("W break after bad stop", w_state, 1'b0);
    check("scan after break", {24'd0, scan_code}, 32'h1D);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000: idle clk cycles tolerated between PS/2 clock falling edges inside a frame (1 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-006 SHALL have port w_state  output  1  high while key W (0x1D) is held.
REQ-007 SHALL have port s_state  output  1  high while key S (0x1B) is held.
REQ-008 SHALL have port Ua_state  output  1  high while Up arrow (E0 75) is held.
REQ-009 SHALL have port Da_state  output  1  high while Down arrow (E0 72) is held.
REQ-010 SHALL have port ESC_state  output  1  high while ESC (0x76) is held.
REQ-011 SHALL have port scan_code  output  8  last correctly received byte.
REQ-012 SHALL have port code_valid  output  1  one-cycle strobe when scan_code updates.
REQ-013 SHALL have port frame_err  output  1  one-cycle strobe on a discarded frame.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers, then detect a falling edge when the previous synced clock is 1 and the current is 0.
REQ-015 SHALL sample synced ps2_data only on detected falling edges.
REQ-016 SHALL run FSM IDLE -> DATA (8 edges, LSB first) -> PARITY -> STOP -> IDLE.
REQ-017 In IDLE, a sampled start bit of 1 SHALL be ignored with no error; 0 SHALL enter DATA.
REQ-018 A stop bit of 0 SHALL discard the frame, pulse frame_err and return to IDLE.
REQ-019 In any non-IDLE state, TIMEOUT_CYC cycles with no falling edge SHALL return to IDLE and pulse frame_err; the counter SHALL clear on every edge and in IDLE.
REQ-020 On a good stop bit, scan_code and code_valid SHALL update on the clk edge following the edge-detect cycle (latency 1 clk from edge detect).
REQ-021 Byte 0xF0 SHALL set a break flag; byte 0xE0 SHALL set an extended flag; neither SHALL change key outputs.
REQ-022 Any other byte SHALL be matched against the key table with the extended flag, set the key output (break clear) or clear it (break set) in the same cycle as code_valid, then clear both flags.
REQ-023 Non-extended 0x75/0x72 and extended 0x1D/0x1B/0x76 SHALL be treated as unknown: no output change, flags cleared.
REQ-024 Multiple keys SHALL be held independently; a repeated make code for a held key SHALL leave it high.
REQ-025 A discarded frame SHALL leave the break and extended flags unchanged.

Reset
REQ-026 With rst high at a clk edge, the FSM SHALL go to IDLE, with bit counter, timeout counter, flags, synchronisers (to 1) cleared.
REQ-027 During reset, all key outputs, code_valid and frame_err SHALL be 0, and scan_code SHALL be 0x00.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a frame_err pulse.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, a parity bit making the 9-bit data+parity count even SHALL discard the frame and pulse frame_err at the stop bit.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored.

Verification
REQ-031 Send frames 1D then F0 1D -> w_state rises with the first code_valid (scan_code=0x1D) and falls with the third.
REQ-032 Send E0 75, then 1D, then E0 F0 75 -> Ua_state=1 and w_state=1 together, then Ua_state=0 while w_state stays 1.
REQ-033 Send 8 bits of a frame, then stop toggling for TIMEOUT_CYC+5 cycles -> one frame_err pulse, FSM in IDLE, next good 0x76 frame sets ESC_state.
REQ-034 With PS2_PARITY_CHECK_EN, send 0x1B with wrong parity -> frame_err pulse, no code_valid, s_state stays 0; without the macro -> s_state=1.
REQ-035 Hold 0x1D, assert rst for 1 cycle mid-frame -> all outputs 0 next cycle, no frame_err, following good frame decoded correctly.
REQ-036 Send frame with stop bit 0 after F0 -> frame_err pulse; next 1D frame is still treated as a break (w_state=0).
